// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader and its byte receiver.
package loader_pkg;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  // Clocks per UART bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit re-check at half a bit,
// mid-bit sampling; emits one-cycle rx_valid or rx_ferr pulses.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  // sync[1] is the synchronized line, sync[2] its previous value for edge detection.
  logic [2:0]       sync;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync     <= 3'b111;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync     <= {sync[1:0], uart_rx};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (sync[2] && !sync[1]) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync[1] ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {sync[1], shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync[1]) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Length-prefixed serial program loader writing 32-bit words into instruction memory.
// Optional trailing XOR checksum enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  load_state_t state;
  logic [7:0]  cnt_lo;
  logic [15:0] n_words;
  logic [15:0] word_cnt;
  logic [1:0]  lane;
  logic [23:0] asm_reg;
  logic        terminal;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  chk_sum;
`endif

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .CLK      (CLK),
    .RESET    (RESET),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign terminal = (state == DONE) || (state == ERR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= CNT_LO;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cnt_lo    <= '0;
      n_words   <= '0;
      word_cnt  <= '0;
      lane      <= '0;
      asm_reg   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      chk_sum   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      // Advance only after a non-final write, so the address never wraps.
      if (mem_we && state == DATA) mem_addr <= mem_addr + 1'b1;
      if (rx_ferr && !terminal) begin
        state    <= ERR;
        busy     <= 1'b0;
        load_err <= 1'b1;
      end else if (rx_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
        chk_sum <= chk_sum ^ rx_data;
`endif
        case (state)
          CNT_LO: begin
            cnt_lo <= rx_data;
            busy   <= 1'b1;
            state  <= CNT_HI;
          end
          CNT_HI: begin
            n_words <= {rx_data, cnt_lo};
            if ({1'b0, rx_data, cnt_lo} > MAX_WORDS) begin
              state    <= ERR;
              busy     <= 1'b0;
              load_err <= 1'b1;
            end else if ({rx_data, cnt_lo} == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state     <= DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            asm_reg <= {rx_data, asm_reg[23:8]};
            lane    <= lane + 1'b1;
            if (lane == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {rx_data, asm_reg};
              word_cnt  <= word_cnt + 1'b1;
              if (word_cnt + 16'd1 == n_words) begin
`ifdef UART_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state     <= DONE;
                busy      <= 1'b0;
                load_done <= 1'b1;
`endif
              end
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          CHK: begin
            busy <= 1'b0;
            if (rx_data == chk_sum) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
